// File: rtl/ysyx_22050535_ifu.sv
// Instruction fetch unit: keeps the PC and fetches one word at a time from imem.
// Decode gets each fetched word with its PC. Redirects from execute can squash a fetch in flight.
module ysyx_22050535_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] inst_r;
  logic        kill;
  logic [31:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~32'h3;

  // All outputs come from registers only, so no input reaches them combinationally.
  assign imem_req_valid = (state == StReq);
  assign inst_valid     = (state == StHold);
  assign imem_req_addr  = pc;
  assign inst_pc        = pc;
  assign inst           = inst_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      pc     <= RESET_PC;
      inst_r <= 32'h0;
      kill   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (redirect_valid) pc <= redir_tgt;
          state <= StReq;
        end
        StReq: begin
          if (redirect_valid) pc <= redir_tgt;
          if (imem_req_ready) begin
            state <= StWait;
            // A redirect during the handshake makes this fetch stale. Drop its response.
            if (redirect_valid) kill <= 1'b1;
          end
        end
        StWait: begin
          if (imem_resp_valid) begin
            if (redirect_valid) begin
              pc    <= redir_tgt;
              kill  <= 1'b0;
              state <= StReq;
            end else if (kill) begin
              kill  <= 1'b0;
              state <= StReq;
            end else begin
              inst_r <= imem_resp_data;
              state  <= StHold;
            end
          end else if (redirect_valid) begin
            pc   <= redir_tgt;
            kill <= 1'b1;
          end
        end
        StHold: begin
          if (inst_ready) begin
            pc    <= redirect_valid ? redir_tgt : pc + 32'd4;
            state <= StReq;
          end else if (redirect_valid) begin
            pc    <= redir_tgt;
            state <= StReq;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
